// File: rtl/ex_accum_pkg.sv
// Shared helpers for the ex_accum_dump accumulate-and-dump slice.
// Width derivation functions used for ACC_W / CH_W and counter sizing.
package ex_accum_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/ex_accum_scale.sv
// Dump-path scaler: arithmetic shift then fit to OUT_WIDTH.
// EX_ACCUM_SAT_EN selects clamping; otherwise two's-complement wrap.
module ex_accum_scale #(
    parameter int ACC_W     = 18,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 18
) (
    input  logic signed [ACC_W-1:0]     acc,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        sat
);

`ifdef EX_ACCUM_SAT_EN
    localparam int W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
    localparam logic signed [W-1:0] HI =
        {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] LO =
        {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [W-1:0] sh;

    always_comb begin
        sh  = W'(acc >>> SHIFT);
        out = sh[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (sh > HI) begin
            out = HI[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (sh < LO) begin
            out = LO[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end
`else
    assign out = OUT_WIDTH'(acc >>> SHIFT);
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/ex_accum_dump.sv
// Multichannel accumulate-and-dump (decimate-by-DEC_N integrator).
// Saturation on the dump path is enabled by defining EX_ACCUM_SAT_EN.
module ex_accum_dump
    import ex_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NCH        = 2,
    parameter int DEC_N      = 4,
    parameter int SHIFT      = 0,
    parameter int OUT_WIDTH  = 18,
    localparam int ACC_W     = DATA_WIDTH + clog2(DEC_N),
    localparam int CH_W      = max1(clog2(NCH))
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         ce,
    input  logic                         clr,
    output logic                         data_valid,
    output logic [CH_W-1:0]              data_ch,
    output logic signed [OUT_WIDTH-1:0]  data_out,
    output logic                         data_sat,
    output logic                         busy
);

    localparam int SW = max1(clog2(DEC_N));
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);
    localparam logic [SW-1:0]   SAMP_LAST = SW'(DEC_N - 1);

    logic signed [ACC_W-1:0] acc    [NCH];
    logic signed [ACC_W-1:0] shadow [NCH];

    logic [CH_W-1:0]         ch_cnt;
    logic [CH_W-1:0]         dump_cnt;
    logic [SW-1:0]           samp_cnt;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] dump_acc;
    logic                    frame_end;
    logic signed [OUT_WIDTH-1:0] sc_out;
    logic                    sc_sat;

    // A channel's first sample of a frame restarts its sum from zero.
    always_comb begin
        base      = (samp_cnt == '0) ? '0 : acc[ch_cnt];
        sum       = base + ACC_W'(data_in);
        frame_end = ce && !clr &&
                    (ch_cnt == CH_LAST) &&
                    (samp_cnt == SAMP_LAST);
        dump_acc  = shadow[dump_cnt];
    end

    ex_accum_scale #(
        .ACC_W     (ACC_W),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_scale (
        .acc (dump_acc),
        .out (sc_out),
        .sat (sc_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]    <= '0;
                shadow[i] <= '0;
            end
            ch_cnt     <= '0;
            samp_cnt   <= '0;
            dump_cnt   <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_ch    <= '0;
            data_out   <= '0;
            data_sat   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            data_sat   <= 1'b0;

            if (busy) begin
                data_valid <= 1'b1;
                data_ch    <= dump_cnt;
                data_out   <= sc_out;
                data_sat   <= sc_sat;
                dump_cnt   <= dump_cnt + 1'b1;
                if (dump_cnt == CH_LAST) busy <= 1'b0;
            end

            if (clr) begin
                ch_cnt   <= '0;
                samp_cnt <= '0;
            end else if (ce) begin
                acc[ch_cnt] <= sum;
                if (ch_cnt == CH_LAST) begin
                    ch_cnt   <= '0;
                    samp_cnt <= (samp_cnt == SAMP_LAST) ?
                                '0 : samp_cnt + 1'b1;
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
                // Last channel's final sum bypasses acc into the shadow.
                if (frame_end) begin
                    for (int i = 0; i < NCH; i++)
                        shadow[i] <= (i == NCH - 1) ? sum : acc[i];
                    busy     <= 1'b1;
                    dump_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_accum_dump.sv
// Randomised + directed bench for ex_accum_dump against a frame-level model.
// Three instances: default, OUT_WIDTH=16, SHIFT=2; same input stream.
module tb_ex_accum_dump;

    localparam int NCH = 2;
    localparam int DEC = 4;

`ifdef EX_ACCUM_SAT_EN
    localparam int SAT_O = 32767;
    localparam int SAT_S = 1;
`else
    localparam int SAT_O = -4;
    localparam int SAT_S = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;
    logic clr = 1'b0;
    logic signed [15:0] din = '0;

    logic v0, v1, v2, c0, c1, c2, s0, s1, s2, b0, b1, b2;
    logic signed [17:0] o0;
    logic signed [15:0] o1;
    logic signed [17:0] o2;

    typedef struct {
        int cyc;
        int ch;
        int sum;
    } exp_t;

    exp_t q[$];
    int   log0[$];
    int   cyc = 0;
    int   pass = 0;
    int   total = 0;
    int   idx = 0;
    int   sums[NCH];
    int   last_out[3][NCH];
    int   last_sat[3][NCH];

    always #5 clk = ~clk;

    ex_accum_dump u_dut0 (
        .clk(clk), .rst(rst), .data_in(din), .ce(ce), .clr(clr),
        .data_valid(v0), .data_ch(c0), .data_out(o0),
        .data_sat(s0), .busy(b0)
    );

    ex_accum_dump #(.OUT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din), .ce(ce), .clr(clr),
        .data_valid(v1), .data_ch(c1), .data_out(o1),
        .data_sat(s1), .busy(b1)
    );

    ex_accum_dump #(.SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(din), .ce(ce), .clr(clr),
        .data_valid(v2), .data_ch(c2), .data_out(o2),
        .data_sat(s2), .busy(b2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                      name, act, exp, $time);
    endtask

    function automatic void scale(input int sum, input int sh,
                                  input int ow, output int o,
                                  output int s);
        int v;
        v = sum >>> sh;
        s = 0;
`ifdef EX_ACCUM_SAT_EN
        begin
            int hi;
            int lo;
            hi = (1 << (ow - 1)) - 1;
            lo = -(1 << (ow - 1));
            if (v > hi) begin
                o = hi;
                s = 1;
            end else if (v < lo) begin
                o = lo;
                s = 1;
            end else begin
                o = v;
            end
        end
`else
        o = (v << (32 - ow)) >>> (32 - ow);
`endif
    endfunction

    // Frame-level model: idx counts accepted samples within a frame.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx = 0;
            q.delete();
        end else if (clr) begin
            idx = 0;
        end else if (ce) begin
            int c;
            c = idx % NCH;
            if (idx < NCH) sums[c] = din;
            else sums[c] += din;
            idx++;
            if (idx == NCH * DEC) begin
                for (int k = 0; k < NCH; k++) begin
                    exp_t e;
                    e.cyc = cyc + 2 + k;
                    e.ch  = k;
                    e.sum = sums[k];
                    q.push_back(e);
                end
                idx = 0;
            end
        end
    end

    task automatic chk_dut(input int id, input logic v, input logic ch,
                           input logic signed [17:0] o, input logic s,
                           input logic b, input int sh, input int ow);
        bit ev;
        bit eb;
        int eo;
        int es;
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        eb = (q.size() > 0) && (q[q.size()-1].cyc > cyc);
        chk($sformatf("valid%0d", id), int'(v), int'(ev));
        chk($sformatf("busy%0d", id), int'(b), int'(eb));
        if (v && ev) begin
            scale(q[0].sum, sh, ow, eo, es);
            chk($sformatf("ch%0d", id), int'(ch), q[0].ch);
            chk($sformatf("out%0d", id), int'(o), eo);
            chk($sformatf("sat%0d", id), int'(s), es);
        end
        if (v) begin
            last_out[id][ch] = int'(o);
            last_sat[id][ch] = int'(s);
            if (id == 0 && ch == 1'b0) log0.push_back(int'(o));
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rst_valid", int'({v0, v1, v2}), 0);
            chk("rst_busy", int'({b0, b1, b2}), 0);
            chk("rst_ch", int'({c0, c1, c2}), 0);
            chk("rst_sat", int'({s0, s1, s2}), 0);
            chk("rst_out", int'(o0) | int'(o1) | int'(o2), 0);
        end else begin
            chk_dut(0, v0, c0, o0, s0, b0, 0, 18);
            chk_dut(1, v1, c1, o1, s1, b1, 0, 16);
            chk_dut(2, v2, c2, o2, s2, b2, 2, 18);
            while (q.size() > 0 && q[0].cyc <= cyc)
                void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic samp(input int d);
        ce  = 1'b1;
        din = d[15:0];
        tick();
        ce  = 1'b0;
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        repeat (n) tick();
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) > 1) idle($urandom_range(1, 3));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        for (int s = 0; s < DEC; s++) begin
            samp(s + 1);
            samp(-1);
        end
        idle(4);
        chk("basic_ch0", last_out[0][0], 10);
        chk("basic_ch1", last_out[0][1], -4);
        chk("basic_sh_ch0", last_out[2][0], 2);
        chk("basic_sh_ch1", last_out[2][1], -1);

        log0.delete();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < DEC; s++) begin
                samp(f + 1);
                gap();
                samp(int'($urandom_range(0, 200)) - 100);
                gap();
            end
        end
        idle(4);
        chk("gap_count", log0.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("gap_f%0d", i),
                (i < log0.size()) ? log0[i] : -999, 4 * (i + 1));

        repeat (3) samp(9);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (NCH * DEC) samp(5);
        idle(4);
        chk("rst_ch0", last_out[0][0], 20);
        chk("rst_ch1", last_out[0][1], 20);

        repeat (5) samp(7);
        clr = 1'b1;
        ce  = 1'b1;
        din = 16'sd100;
        tick();
        clr = 1'b0;
        ce  = 1'b0;
        repeat (NCH * DEC) samp(2);
        idle(4);
        chk("clr_ch0", last_out[0][0], 8);
        chk("clr_ch1", last_out[0][1], 8);

        repeat (NCH * DEC) samp(32767);
        idle(4);
        chk("sat16_out", last_out[1][0], SAT_O);
        chk("sat16_flag", last_sat[1][0], SAT_S);
        chk("sat18_out", last_out[0][1], 131068);
        chk("sat18_flag", last_sat[0][1], 0);

        for (int s = 0; s < DEC; s++) begin
            samp((s == 3) ? -2 : -1);
            samp(3);
        end
        idle(4);
        chk("shift_ch0", last_out[2][0], -2);
        chk("shift_ch1", last_out[2][1], 3);

        repeat (300) begin
            if ($urandom_range(0, 29) == 0) begin
                clr = 1'b1;
                ce  = 1'($urandom_range(0, 1));
                din = 16'($urandom);
                tick();
                clr = 1'b0;
                ce  = 1'b0;
            end
            samp(int'($urandom));
            gap();
        end

        idle(8);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
